axi_lite_b_resp_router: RTL and testbench

Write-response return path of the AXI-Lite interconnect, one instance per slave port. For every AW handshake it records the one-hot master ID granted by the slave's arbiter/ID mux in an in-order ID FIFO. It then steers each B response from the slave back to the master at the FIFO head, with the B valid/ready handshake on each side. This is the counterpart of the per-slave ID selection on the request path.

---
 rtl/axi_lite_ic_pkg.sv | 47 ++++
 rtl/axi_lite_b_resp_router_if.sv | 36 +++
 rtl/id_fifo.sv | 81 ++++++++
 rtl/axi_lite_b_resp_router.sv | 136 +++++++++++++
 tb/tb_axi_lite_b_resp_router.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_ic_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_ic_pkg
// Shared definitions for the AXI-Lite interconnect:
//   - BRESP encodings (OKAY, EXOKAY, SLVERR, DECERR)
//   - B-return FSM state type (IDLE, HOLD)
//   - one-hot check and one-hot-to-index helpers (vectors up to MAX_MASTERS)
// ---------------------------------------------------------------------------
package axi_lite_ic_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Helpers take vectors zero-extended to this width.
    localparam int MAX_MASTERS = 32;
    localparam int MAX_IDX_W   = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } b_state_e;

    // True when exactly one bit of vec is set.
    function automatic logic is_onehot(input logic [MAX_MASTERS-1:0] vec);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            multi = multi | (seen & vec[i]);
            seen  = seen | vec[i];
        end
        return seen & ~multi;
    endfunction

    // Index of the set bit; OR-reduction keeps it a pure mux-free encoder.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = {MAX_IDX_W{1'b0}};
        for (int i = 0; i < MAX_MASTERS; i++) begin
            idx = idx | (vec[i] ? MAX_IDX_W'(i) : {MAX_IDX_W{1'b0}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_lite_b_resp_router_if.sv
// ---------------------------------------------------------------------------
// axi_lite_b_resp_router_if
// Bundles the AW bookkeeping, slave-side B channel and per-master B channels
// of one B-response router.
//   master modport : environment side (drives grant/aw_hs, slave B, master bready)
//   slave modport  : router side
// ---------------------------------------------------------------------------
interface axi_lite_b_resp_router_if #(
    parameter int NUM_MASTERS = 4,
    parameter int DEPTH       = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_MASTERS-1:0]   grant_id_i;
    logic                     aw_hs_i;
    logic                     full_o;
    logic                     empty_o;
    logic [CNT_W-1:0]         outstanding_o;
    logic                     s_bvalid_i;
    logic [1:0]               s_bresp_i;
    logic                     s_bready_o;
    logic [NUM_MASTERS-1:0]   m_bvalid_o;
    logic [2*NUM_MASTERS-1:0] m_bresp_o;
    logic [NUM_MASTERS-1:0]   m_bready_i;
    logic                     err_o;

    modport master (
        output grant_id_i, aw_hs_i, s_bvalid_i, s_bresp_i, m_bready_i,
        input  full_o, empty_o, outstanding_o, s_bready_o, m_bvalid_o, m_bresp_o, err_o
    );

    modport slave (
        input  grant_id_i, aw_hs_i, s_bvalid_i, s_bresp_i, m_bready_i,
        output full_o, empty_o, outstanding_o, s_bready_o, m_bvalid_o, m_bresp_o, err_o
    );
endinterface

// File: rtl/id_fifo.sv
// ---------------------------------------------------------------------------
// id_fifo
// Synchronous in-order FIFO holding one-hot master IDs of outstanding writes.
//   push/wdata : enqueue (ignored when full)
//   pop        : dequeue (ignored when empty)
//   head       : entry at the read pointer
//   full/empty/count : registered occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module id_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;

    logic             push_ok_s;
    logic             pop_ok_s;
    logic [CNT_W-1:0] count_nxt_s;

    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and registered status flags.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/axi_lite_b_resp_router.sv
// ---------------------------------------------------------------------------
// axi_lite_b_resp_router
// Per-slave write-response return path. Records the granted master ID on every
// AW handshake and steers each slave B response back to the master at the
// head of the ID FIFO, strictly in AW order.
//   clk_i, resetn_i : clock, asynchronous active-low reset
//   bus (slave)     : grant_id_i/aw_hs_i push side, full/empty/outstanding
//                     status, slave B channel, per-master B channels, err_o
// ---------------------------------------------------------------------------
module axi_lite_b_resp_router
    import axi_lite_ic_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DEPTH       = 4
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    axi_lite_b_resp_router_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_HOLD = HOLD;

    logic [MAX_MASTERS-1:0]   grant_ext_s;
    logic [MAX_MASTERS-1:0]   head_ext_s;
    logic                     grant_ok_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [NUM_MASTERS-1:0]   head_s;
    logic [IDX_W-1:0]         head_idx_s;
    logic [CNT_W-1:0]         count_s;
    logic                     s_bready_s;
    logic                     s_hs_s;
    logic                     bad_push_s;
    logic                     bad_resp_s;

    logic [0:0]               state_r;
    logic [0:0]               state_nxt_s;
    logic [NUM_MASTERS-1:0]   m_bvalid_r;
    logic [NUM_MASTERS-1:0]   m_bvalid_nxt_s;
    logic [2*NUM_MASTERS-1:0] m_bresp_r;
    logic [2*NUM_MASTERS-1:0] m_bresp_nxt_s;
    logic                     err_r;

    assign grant_ext_s = MAX_MASTERS'(bus.grant_id_i);
    assign head_ext_s  = MAX_MASTERS'(head_s);
    assign grant_ok_s  = is_onehot(grant_ext_s);
    assign head_idx_s  = IDX_W'(onehot_to_idx(head_ext_s));

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push_s     = bus.aw_hs_i & grant_ok_s & ~fifo_full_s;
    assign bad_push_s = bus.aw_hs_i & (~grant_ok_s | fifo_full_s);
    assign bad_resp_s = bus.s_bvalid_i & fifo_empty_s;

    // Only the head master's BREADY can complete the held response.
    assign pop_s      = (state_r == ST_HOLD) & bus.m_bready_i[head_idx_s];
    assign s_bready_s = (state_r == ST_IDLE) & ~fifo_empty_s;
    assign s_hs_s     = bus.s_bvalid_i & s_bready_s;

    id_fifo #(
        .WIDTH (NUM_MASTERS),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push     (push_s),
        .pop      (pop_s),
        .wdata    (bus.grant_id_i),
        .head     (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (count_s)
    );

    // FSM next state plus the response register and lane steering.
    always_comb begin
        state_nxt_s    = state_r;
        m_bvalid_nxt_s = m_bvalid_r;
        m_bresp_nxt_s  = m_bresp_r;
        case (state_r)
            ST_IDLE: begin
                if (s_hs_s) begin
                    state_nxt_s    = ST_HOLD;
                    m_bvalid_nxt_s = head_s;
                    for (int k = 0; k < NUM_MASTERS; k++) begin
                        m_bresp_nxt_s[2*k +: 2] = head_s[k] ? bus.s_bresp_i : 2'b00;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (pop_s) begin
                    state_nxt_s    = ST_IDLE;
                    m_bvalid_nxt_s = {NUM_MASTERS{1'b0}};
                    m_bresp_nxt_s  = {(2*NUM_MASTERS){1'b0}};
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                m_bvalid_nxt_s = {NUM_MASTERS{1'b0}};
                m_bresp_nxt_s  = {(2*NUM_MASTERS){1'b0}};
            end
        endcase
    end

    // State, held response and sticky error flag.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r    <= ST_IDLE;
            m_bvalid_r <= {NUM_MASTERS{1'b0}};
            m_bresp_r  <= {(2*NUM_MASTERS){1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            m_bvalid_r <= m_bvalid_nxt_s;
            m_bresp_r  <= m_bresp_nxt_s;
            err_r      <= err_r | bad_push_s | bad_resp_s;
        end
    end

    assign bus.full_o        = fifo_full_s;
    assign bus.empty_o       = fifo_empty_s;
    assign bus.outstanding_o = count_s;
    assign bus.s_bready_o    = s_bready_s;
    assign bus.m_bvalid_o    = m_bvalid_r;
    assign bus.m_bresp_o     = m_bresp_r;
    assign bus.err_o         = err_r;

endmodule

// File: tb/tb_axi_lite_b_resp_router.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_b_resp_router
// Self-checking bench: a reference ID queue models the FIFO, and every
// response handed to the slave side pushes its expected lane/BRESP into a
// scoreboard that is popped when the master side completes it.
// ---------------------------------------------------------------------------
module tb_axi_lite_b_resp_router;
    import axi_lite_ic_pkg::*;

    localparam int NM    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [NM-1:0] lane;
        logic [1:0]    resp;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [NM-1:0] id_q [$];
    exp_t          sb_q [$];
    logic          err_exp = 1'b0;

    always #5 clk = ~clk;

    axi_lite_b_resp_router_if #(.NUM_MASTERS(NM), .DEPTH(DEPTH)) bus ();

    axi_lite_b_resp_router #(.NUM_MASTERS(NM), .DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    // Expected per-master BRESP vector: resp on the lane's bits, zeros elsewhere.
    function automatic logic [2*NM-1:0] lanes_of(input exp_t e);
        logic [2*NM-1:0] v;
        v = '0;
        for (int k = 0; k < NM; k++) begin
            if (e.lane[k]) v[2*k +: 2] = e.resp;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [NM-1:0] g);
        if ($countones(g) == 1 && id_q.size() < DEPTH) id_q.push_back(g);
        else err_exp = 1'b1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.aw_hs_i = 1'b0; bus.grant_id_i = '0;
        bus.s_bvalid_i = 1'b0; bus.s_bresp_i = 2'b00; bus.m_bready_i = '0;
        id_q.delete(); sb_q.delete(); err_exp = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic push(input logic [NM-1:0] g);
        bus.grant_id_i = g; bus.aw_hs_i = 1'b1;
        tick();
        model_push(g);
        bus.aw_hs_i = 1'b0; bus.grant_id_i = '0;
    endtask

    // Offer one slave response; bounded wait for s_bready_o.
    task automatic slave_resp(input logic [1:0] resp, output bit acc);
        bit done;
        acc = 1'b0; done = 1'b0;
        bus.s_bvalid_i = 1'b1; bus.s_bresp_i = resp;
        for (int i = 0; i < 20; i++) begin
            if (!done) begin
                if (bus.s_bready_o === 1'b1) begin
                    if (id_q.size() > 0) sb_q.push_back({id_q[0], resp});
                    acc = 1'b1; done = 1'b1;
                end
                tick();
            end
        end
        bus.s_bvalid_i = 1'b0;
    endtask

    // One full transaction: slave response, one stall cycle with only
    // non-head readies, then the head handshake (optionally with a push).
    task automatic deliver(input logic [1:0] resp, input logic [NM-1:0] nonhead,
                           input logic [NM-1:0] push_g, output bit acc,
                           output logic [NM-1:0] v1, output logic [2*NM-1:0] r1,
                           output logic [NM-1:0] v2, output logic [2*NM-1:0] r2,
                           output logic [NM-1:0] v3, output logic [CW-1:0] occ3);
        logic [NM-1:0] lane;
        lane = (id_q.size() > 0) ? id_q[0] : '0;
        slave_resp(resp, acc);
        v1 = bus.m_bvalid_o; r1 = bus.m_bresp_o;
        bus.m_bready_i = nonhead & ~lane;
        tick();
        v2 = bus.m_bvalid_o; r2 = bus.m_bresp_o;
        bus.m_bready_i = lane | (nonhead & ~lane);
        if (push_g != '0) begin bus.aw_hs_i = 1'b1; bus.grant_id_i = push_g; end
        tick();
        if (push_g != '0) model_push(push_g);
        if (acc && id_q.size() > 0) void'(id_q.pop_front());
        bus.aw_hs_i = 1'b0; bus.grant_id_i = '0; bus.m_bready_i = '0;
        v3 = bus.m_bvalid_o; occ3 = bus.outstanding_o;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.m_bvalid_o !== '0)     begin miscompares++; $display("FAIL reset_bvalid got %b want 0", bus.m_bvalid_o); end
        vectors++; if (bus.m_bresp_o !== '0)      begin miscompares++; $display("FAIL reset_bresp got %b want 0", bus.m_bresp_o); end
        vectors++; if (bus.s_bready_o !== 1'b0)   begin miscompares++; $display("FAIL reset_sbready got %b want 0", bus.s_bready_o); end
        vectors++; if (bus.err_o !== 1'b0)        begin miscompares++; $display("FAIL reset_err got %b want 0", bus.err_o); end
        vectors++; if ({bus.empty_o, bus.full_o, bus.outstanding_o} !== {1'b1, 1'b0, CW'(0)})
            begin miscompares++; $display("FAIL reset_fifo got e%b f%b n%0d want e1 f0 n0", bus.empty_o, bus.full_o, bus.outstanding_o); end
    endtask

    task automatic test_single();
        bit acc; logic [NM-1:0] v1, v2, v3; logic [2*NM-1:0] r1, r2; logic [CW-1:0] occ; exp_t e;
        do_reset();
        push(4'b0100);
        vectors++; if ({bus.outstanding_o, bus.empty_o, bus.s_bready_o} !== {CW'(1), 1'b0, 1'b1})
            begin miscompares++; $display("FAIL single_push got n%0d e%b r%b want n1 e0 r1", bus.outstanding_o, bus.empty_o, bus.s_bready_o); end
        deliver(SLVERR, 4'b1011, '0, acc, v1, r1, v2, r2, v3, occ);
        vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL single_acc got %b want 1", acc); end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        vectors++; if (v1 !== 4'b0100 || r1 !== 8'b0010_0000)
            begin miscompares++; $display("FAIL single_out got v%b r%b want v0100 r00100000", v1, r1); end
        vectors++; if (v2 !== e.lane || r2 !== lanes_of(e))
            begin miscompares++; $display("FAIL single_hold got v%b r%b want v%b r%b", v2, r2, e.lane, lanes_of(e)); end
        vectors++; if (v3 !== '0 || bus.empty_o !== 1'b1 || occ !== CW'(0))
            begin miscompares++; $display("FAIL single_done got v%b e%b n%0d want v0 e1 n0", v3, bus.empty_o, occ); end
    endtask

    task automatic test_in_order();
        logic [NM-1:0] g [3] = '{4'b0001, 4'b1000, 4'b0010};
        logic [1:0]    rs [3] = '{OKAY, SLVERR, DECERR};
        bit acc; logic [NM-1:0] v1, v2, v3; logic [2*NM-1:0] r1, r2; logic [CW-1:0] occ; exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) push(g[i]);
        for (int i = 0; i < 3; i++) begin
            deliver(rs[i], 4'b1111, '0, acc, v1, r1, v2, r2, v3, occ);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            vectors++; if (acc !== 1'b1 || e.lane !== g[i])
                begin miscompares++; $display("FAIL inorder_acc[%0d] got acc%b lane%b want acc1 lane%b", i, acc, e.lane, g[i]); end
            vectors++; if (v1 !== g[i] || r1 !== lanes_of(e))
                begin miscompares++; $display("FAIL inorder_out[%0d] got v%b r%b want v%b r%b", i, v1, r1, g[i], lanes_of(e)); end
            vectors++; if (v2 !== g[i] || r2 !== lanes_of(e))
                begin miscompares++; $display("FAIL inorder_hold[%0d] got v%b r%b want v%b r%b", i, v2, r2, g[i], lanes_of(e)); end
            vectors++; if (v3 !== '0 || occ !== CW'(2 - i) || bus.s_bready_o !== (i < 2))
                begin miscompares++; $display("FAIL inorder_pop[%0d] got v%b n%0d r%b want v0 n%0d r%b", i, v3, occ, bus.s_bready_o, 2 - i, i < 2); end
        end
        vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL inorder_err got %b want 0", bus.err_o); end
    endtask

    task automatic test_full_overflow();
        logic [NM-1:0] g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [1:0]    rs [4] = '{OKAY, EXOKAY, SLVERR, DECERR};
        bit acc; logic [NM-1:0] v1, v2, v3; logic [2*NM-1:0] r1, r2; logic [CW-1:0] occ; exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) push(g[i]);
        vectors++; if (bus.full_o !== 1'b1 || bus.outstanding_o !== CW'(4) || bus.err_o !== 1'b0)
            begin miscompares++; $display("FAIL full_four got f%b n%0d err%b want f1 n4 err0", bus.full_o, bus.outstanding_o, bus.err_o); end
        push(4'b0001);
        vectors++; if (bus.outstanding_o !== CW'(4) || bus.err_o !== err_exp || err_exp !== 1'b1)
            begin miscompares++; $display("FAIL full_overflow got n%0d err%b want n4 err1", bus.outstanding_o, bus.err_o); end
        for (int i = 0; i < 4; i++) begin
            // first drain cycle also pushes while full; that push must be dropped
            deliver(rs[i], '0, (i == 0) ? 4'b0010 : 4'b0000, acc, v1, r1, v2, r2, v3, occ);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            vectors++; if (acc !== 1'b1 || v1 !== g[i] || r1 !== lanes_of(e) || e.lane !== g[i])
                begin miscompares++; $display("FAIL full_drain[%0d] got acc%b v%b r%b want v%b r%b", i, acc, v1, r1, g[i], lanes_of(e)); end
            vectors++; if (v3 !== '0 || occ !== CW'(id_q.size()) || occ !== CW'(3 - i))
                begin miscompares++; $display("FAIL full_occ[%0d] got v%b n%0d want v0 n%0d", i, v3, occ, 3 - i); end
        end
        vectors++; if (bus.empty_o !== 1'b1 || bus.err_o !== 1'b1)
            begin miscompares++; $display("FAIL full_end got e%b err%b want e1 err1", bus.empty_o, bus.err_o); end
    endtask

    task automatic test_back_to_back();
        bit acc; logic [NM-1:0] v1, v2, v3; logic [2*NM-1:0] r1, r2; logic [CW-1:0] occ; exp_t e;
        logic [NM-1:0] pg;
        do_reset();
        push(4'b0001); push(4'b0010);
        for (int i = 0; i < 11; i++) begin
            pg = (i < 9) ? (NM'(1) << ((i + 2) % NM)) : '0;
            deliver(2'(i), '0, pg, acc, v1, r1, v2, r2, v3, occ);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            vectors++; if (acc !== 1'b1 || e.lane !== (NM'(1) << (i % NM)) || v1 !== e.lane || r1 !== lanes_of(e))
                begin miscompares++; $display("FAIL b2b_out[%0d] got acc%b v%b r%b want v%b r%b", i, acc, v1, r1, NM'(1) << (i % NM), lanes_of(e)); end
            vectors++; if (occ !== ((i < 9) ? CW'(2) : CW'(10 - i)))
                begin miscompares++; $display("FAIL b2b_occ[%0d] got %0d want %0d", i, occ, (i < 9) ? 2 : 10 - i); end
        end
        vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL b2b_err got %b want 0", bus.err_o); end
    endtask

    task automatic test_errors();
        do_reset();
        push(4'b0110);
        vectors++; if (bus.outstanding_o !== CW'(0) || bus.err_o !== 1'b1)
            begin miscompares++; $display("FAIL err_multihot got n%0d err%b want n0 err1", bus.outstanding_o, bus.err_o); end
        do_reset();
        push(4'b0000);
        vectors++; if (bus.outstanding_o !== CW'(0) || bus.err_o !== 1'b1)
            begin miscompares++; $display("FAIL err_zero got n%0d err%b want n0 err1", bus.outstanding_o, bus.err_o); end
        do_reset();
        bus.s_bvalid_i = 1'b1; bus.s_bresp_i = OKAY;
        #1;
        vectors++; if (bus.s_bready_o !== 1'b0) begin miscompares++; $display("FAIL err_unexp_ready got %b want 0", bus.s_bready_o); end
        tick();
        bus.s_bvalid_i = 1'b0;
        vectors++; if (bus.err_o !== 1'b1 || bus.m_bvalid_o !== '0)
            begin miscompares++; $display("FAIL err_unexp got err%b v%b want err1 v0", bus.err_o, bus.m_bvalid_o); end
    endtask

    task automatic test_reset_in_hold();
        bit acc; logic [NM-1:0] v1, v2, v3; logic [2*NM-1:0] r1, r2; logic [CW-1:0] occ; exp_t e;
        do_reset();
        push(4'b1000); push(4'b0001);
        slave_resp(DECERR, acc);
        vectors++; if (acc !== 1'b1 || bus.m_bvalid_o !== 4'b1000 || bus.m_bresp_o !== 8'b1100_0000)
            begin miscompares++; $display("FAIL rsthold_pre got acc%b v%b r%b want acc1 v1000 r11000000", acc, bus.m_bvalid_o, bus.m_bresp_o); end
        #2 resetn = 1'b0;
        #1;
        vectors++; if (bus.m_bvalid_o !== '0 || bus.m_bresp_o !== '0 || bus.s_bready_o !== 1'b0 || bus.err_o !== 1'b0)
            begin miscompares++; $display("FAIL rsthold_out got v%b r%b rdy%b err%b want all 0", bus.m_bvalid_o, bus.m_bresp_o, bus.s_bready_o, bus.err_o); end
        vectors++; if ({bus.empty_o, bus.full_o, bus.outstanding_o} !== {1'b1, 1'b0, CW'(0)})
            begin miscompares++; $display("FAIL rsthold_fifo got e%b f%b n%0d want e1 f0 n0", bus.empty_o, bus.full_o, bus.outstanding_o); end
        id_q.delete(); sb_q.delete(); err_exp = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        push(4'b0010);
        deliver(EXOKAY, '0, '0, acc, v1, r1, v2, r2, v3, occ);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        vectors++; if (acc !== 1'b1 || v1 !== 4'b0010 || r1 !== 8'b0000_0100 || e.lane !== 4'b0010)
            begin miscompares++; $display("FAIL rsthold_after got acc%b v%b r%b want acc1 v0010 r00000100", acc, v1, r1); end
        vectors++; if (v3 !== '0 || occ !== CW'(0))
            begin miscompares++; $display("FAIL rsthold_pop got v%b n%0d want v0 n0", v3, occ); end
    endtask

    initial begin
        bus.aw_hs_i = 1'b0; bus.grant_id_i = '0;
        bus.s_bvalid_i = 1'b0; bus.s_bresp_i = 2'b00; bus.m_bready_i = '0;
        test_reset();
        test_single();
        test_in_order();
        test_full_overflow();
        test_back_to_back();
        test_errors();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
